fact_cu: RTL and testbench
==========================

Name: fact_cu

Overview:
- Control unit for the factorial datapath (Factorio_DP).
- Sequences the DP control inputs: sel1, sel2, reg_load, cnt_load, cnt_en.
- Consumes the DP flags GT_flag (count > 1) and Err (N > 12).
- Presents a go/done/error/busy handshake to the system side. fact_cu plus Factorio_DP together form the complete factorial engine.

Parameters:
- GO_EDGE, 1, 1 = start on a rising edge of go only; 0 = start whenever go is high in a start-capable state.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- go  in  1  start request
- GT_flag  in  1  from DP; DP count > 1
- Err  in  1  from DP; N > 12 (overflow of the 32-bit result)
- sel1  out  1  to DP reg mux; 0 = constant 1, 1 = product
- sel2  out  1  to DP output mux; 1 = OUT shows the register, 0 = OUT forced to 0
- reg_load  out  1  DP register write enable
- cnt_load  out  1  DP counter loads N
- cnt_en  out  1  DP counter decrements by 1
- done  out  1  result valid on DP OUT
- error  out  1  last request was rejected (N > 12)
- busy  out  1  computation in progress

Behaviour:
- Clocking/reset: single clock domain; all registers update on the rising edge of clk.
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0.
  - The go edge register resets to 1, so go must be seen low before the first edge start.
- Reset mid-operation: abort at the next edge, return to IDLE, outputs 0. The DP register value is don't-care.
- Start condition, evaluated in IDLE, DONE and ERROR:
  - GO_EDGE=1: start = go & ~go_q.
  - GO_EDGE=0: start = go.
- Control outputs are Moore, decoded from the state register. Unlisted outputs are 0.
- States:
  - IDLE: busy=0.
    - start & Err -> ERROR.
    - start & ~Err -> INIT.
    - otherwise stay.
  - INIT: cnt_load=1, reg_load=1, sel1=0 (reg <= 1, cnt <= N); busy=1. -> CHECK.
  - CHECK: busy=1.
    - GT_flag -> MUL.
    - else -> DONE.
  - MUL: reg_load=1, sel1=1, cnt_en=1 (reg <= reg*cnt, cnt <= cnt-1); busy=1. -> CHECK.
  - DONE: done=1, sel2=1. Held until the next start, which follows the same Err check as IDLE.
  - ERROR: error=1, sel2=0 (OUT reads 0). Held until the next start, with the same Err check.
- Latency, measured from the clock edge that samples start (edge 0):
  - N >= 2: done rises after edge 2N (INIT, N-1 CHECK/MUL pairs, final CHECK).
  - N = 0 or 1: done rises after edge 2; OUT = 1.
- done and error are mutually exclusive and never high together with busy.
- go is ignored while busy=1. A go edge that occurs while busy is lost.
- With GO_EDGE=0 and go held high, DONE re-enters INIT immediately, so done is high for exactly 1 cycle per result.
- Err is sampled only at start. A change in N during computation is undefined at the system level; fact_cu keeps sequencing.
- Illegal state encodings -> IDLE on the next edge.

Optional Feature:
- Macro: FACT_CU_FAST_EN.
- Defined:
  - The CHECK state is removed. INIT -> MUL.
  - In MUL, the outputs reg_load/sel1/cnt_en are gated by GT_flag.
  - MUL stays in MUL while GT_flag=1; GT_flag=0 -> DONE.
  - Latency becomes done after edge N+1 for N >= 2, and after edge 2 for N <= 1.
- Undefined: the five-state flow above, with 2N latency.
- The handshake, error handling and reset behaviour are identical in both builds.

Test Plan:
- Reset, then N=5, go pulse -> done after edge 10 (edge 6 with FAST), OUT=120, busy high in between, error=0.
- N=0 and N=1 -> done after edge 2, OUT=1. N=12 -> OUT=479001600.
- N=13, go -> ERROR next cycle: error=1, busy=0, OUT=0. Then N=3, go -> clears to a normal run, OUT=6.
- GO_EDGE=1: go held high through the run -> exactly one computation. go low then high -> second run.
- GO_EDGE=0: go held high -> continuous back-to-back runs, done pulses of 1 cycle each.
- reset asserted during MUL at N=7 -> IDLE next edge, all outputs 0. A new go with N=4 -> OUT=24.

Source files
------------

// File: rtl/fact_cu.sv
// fact_cu: go/done/error/busy sequencer for the factorial datapath.
// Define FACT_CU_FAST_EN to fold CHECK into MUL (N+1 cycle latency).
module fact_cu #(
   parameter bit GO_EDGE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic go,
   input  logic GT_flag,
   input  logic Err,
   output logic sel1,
   output logic sel2,
   output logic reg_load,
   output logic cnt_load,
   output logic cnt_en,
   output logic done,
   output logic error,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      CHECK = 3'd2,
      MUL   = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   state_t state;
   state_t state_nx;
   logic   go_q;
   logic   start;
   state_t launch;

   // go_q resets high so a go already asserted at reset is not an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         go_q  <= 1'b1;
      end else begin
         state <= state_nx;
         go_q  <= go;
      end
   end

   assign start  = GO_EDGE ? (go & ~go_q) : go;
   assign launch = Err ? ERROR : INIT;

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:  state_nx = start ? launch : IDLE;
         DONE:  state_nx = start ? launch : DONE;
         ERROR: state_nx = start ? launch : ERROR;
`ifdef FACT_CU_FAST_EN
         INIT:  state_nx = MUL;
         MUL:   state_nx = GT_flag ? MUL : DONE;
`else
         INIT:  state_nx = CHECK;
         CHECK: state_nx = GT_flag ? MUL : DONE;
         MUL:   state_nx = CHECK;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sel1     = 1'b0;
      sel2     = 1'b0;
      reg_load = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      busy     = 1'b0;
      case (state)
         INIT: begin
            cnt_load = 1'b1;
            reg_load = 1'b1;
            busy     = 1'b1;
         end
`ifndef FACT_CU_FAST_EN
         CHECK: busy = 1'b1;
         MUL: begin
            reg_load = 1'b1;
            sel1     = 1'b1;
            cnt_en   = 1'b1;
            busy     = 1'b1;
         end
`else
         // the last MUL cycle only observes GT_flag low and must not multiply
         MUL: begin
            reg_load = GT_flag;
            sel1     = GT_flag;
            cnt_en   = GT_flag;
            busy     = 1'b1;
         end
`endif
         DONE: begin
            done = 1'b1;
            sel2 = 1'b1;
         end
         ERROR: error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fact_cu.sv
// tb_fact_cu: scoreboard bench for fact_cu driving a behavioural factorial datapath.
// Instance 0 uses GO_EDGE=1, instance 1 uses GO_EDGE=0.
module tb_fact_cu;

`ifdef FACT_CU_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  go;
   logic [1:0]  gt, err, sel1, sel2, rl, cl, ce, done, error, busy;
   logic [4:0]  n   [2];
   logic [4:0]  cnt [2];
   logic [31:0] acc [2];
   logic [31:0] out [2];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int          start;
      int          due;
      bit          is_err;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar i = 0; i < 2; i++) begin : g_dut
      fact_cu #(.GO_EDGE(i == 0 ? 1'b1 : 1'b0)) dut (
         .clk(clk), .reset(reset), .go(go[i]),
         .GT_flag(gt[i]), .Err(err[i]),
         .sel1(sel1[i]), .sel2(sel2[i]),
         .reg_load(rl[i]), .cnt_load(cl[i]), .cnt_en(ce[i]),
         .done(done[i]), .error(error[i]), .busy(busy[i])
      );
      // datapath model: counter, product register, output mux
      always @(posedge clk) begin
         if (cl[i]) cnt[i] <= n[i];
         else if (ce[i]) cnt[i] <= cnt[i] - 5'd1;
         if (rl[i]) acc[i] <= sel1[i] ? acc[i] * {27'd0, cnt[i]} : 32'd1;
      end
      assign gt[i]  = cnt[i] > 5'd1;
      assign err[i] = n[i] > 5'd12;
      assign out[i] = sel2[i] ? acc[i] : 32'd0;
   end

   function automatic logic [31:0] fact(input int k);
      logic [31:0] r = 32'd1;
      for (int j = 2; j <= k; j++) r = r * j;
      return r;
   endfunction

   function automatic int lat(input int k);
      if (k <= 1) return 2;
      return FAST ? k + 1 : 2 * k;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // called at a negedge with go rising; the next posedge is edge 0
   task automatic push_job(input int k);
      exp_t e;
      e.start  = cyc + 1;
      e.is_err = (k > 12);
      e.due    = e.start + (e.is_err ? 0 : lat(k));
      e.res    = e.is_err ? 32'd0 : fact(k);
      sb.push_back(e);
   endtask

   task automatic wait_empty();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         check("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run(input int k);
      @(negedge clk);
      n[0]  = k[4:0];
      go[0] = 1'b1;
      push_job(k);
      @(negedge clk);
      go[0] = 1'b0;
      wait_empty();
   endtask

   // monitor for instance 0
   initial begin
      logic dp = 1'b0;
      logic ep = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("exclusive", (done[0] & error[0]) | (busy[0] & (done[0] | error[0])), 0);
            if (sb.size() > 0 && !sb[0].is_err && cyc >= sb[0].start && cyc < sb[0].due)
               check("busy_during_run", busy[0], 1);
            if ((done[0] && !dp) || (error[0] && !ep)) begin
               if (sb.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("result_cycle", cyc, e.due);
                  check("error_flag", error[0], e.is_err);
                  check("done_flag", done[0], !e.is_err);
                  check("out_value", out[0], e.res);
               end
            end
         end
         dp = done[0];
         ep = error[0];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  k;
      bit  last_err;
      int  t;
      int  rises;
      int  last_rise;
      int  period;
      logic p;

      go   = 2'b00;
      n[0] = 5'd0;
      n[1] = 5'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs0", {sel1[0], sel2[0], rl[0], cl[0], ce[0], done[0], error[0], busy[0]}, 0);
      check("reset_outs1", {sel1[1], sel2[1], rl[1], cl[1], ce[1], done[1], error[1], busy[1]}, 0);
      reset = 1'b0;
      @(negedge clk);

      run(5);
      run(0);
      run(1);
      run(12);
      run(13);
      run(3);

      last_err = 1'b0;
      for (int i = 0; i < 16; i++) begin
         k = $urandom_range(0, 14);
         if (last_err && k > 12) k = $urandom_range(0, 12);
         run(k);
         last_err = (k > 12);
      end

      // go held high with edge start: one run only, then a fresh edge restarts
      @(negedge clk);
      n[0]  = 5'd4;
      go[0] = 1'b1;
      push_job(4);
      repeat (40) @(negedge clk);
      check("held_go_single_run", sb.size(), 0);
      go[0] = 1'b0;
      @(negedge clk);
      run(4);

      // reset while multiplying
      @(negedge clk);
      n[0]  = 5'd7;
      go[0] = 1'b1;
      push_job(7);
      @(negedge clk);
      go[0] = 1'b0;
      t = 0;
      while (!ce[0] && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("reached_mul", ce[0], 1);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrun_reset_outs", {sel1[0], sel2[0], rl[0], cl[0], ce[0], done[0], error[0], busy[0]}, 0);
      reset = 1'b0;
      @(negedge clk);
      run(4);

      // level start: back-to-back runs, one-cycle done pulses
      period    = lat(3) + 1;
      rises     = 0;
      last_rise = -1;
      p         = 1'b0;
      @(negedge clk);
      n[1]  = 5'd3;
      go[1] = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (p) check("lvl_pulse_width", done[1], 0);
         if (done[1] && !p) begin
            rises++;
            check("lvl_out", out[1], 6);
            if (last_rise >= 0) check("lvl_period", cyc - last_rise, period);
            last_rise = cyc;
         end
         p = done[1];
      end
      check("lvl_runs", rises >= 3, 1);
      go[1] = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
